// File: rtl/axi_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) between the burst master and a slave.
// Master drives addresses, write data and the R/B readies.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command becomes one FIXED/INCR
// burst, read data passes straight through, and the worst response is kept.
module axi_burst_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [1:0]        cmd_burst,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic [1:0]        resp,
    output logic              err_cmd,
    output logic              busy,
    axi_if.master             m_axi
);
    localparam logic [2:0] SIZE   = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam logic [8:0] MAX_L  = 9'(MAX_LEN);
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic [1:0]        burst_q;
    logic [1:0]        resp_q;
    logic              err_q;

    logic        cmd_hs, reject, last_beat;
    logic        r_hs, w_hs, b_hs, a_hs;
    logic [13:0] span;
    logic [1:0]  r_code;

    assign cmd_hs    = cmd_valid && (state == IDLE);
    assign span      = ({6'd0, cmd_len} + 14'd1) << SIZE;
    assign reject    = ({1'b0, cmd_len} >= MAX_L)
                    || (cmd_burst != FIXED && cmd_burst != INCR)
                    || (cmd_burst == INCR
                        && ({2'b0, cmd_addr[11:0]} + span) > 14'd4096);
    assign last_beat = beat_cnt == len_q;

    assign a_hs = (state == RADDR && m_axi.arready)
               || (state == WADDR && m_axi.awready);
    assign r_hs = state == RDATA && m_axi.rvalid && rd_ready;
    assign w_hs = state == WDATA && wd_valid && m_axi.wready;
    assign b_hs = state == WRESP && m_axi.bvalid;

    // A slave rlast that disagrees with our own beat count is a protocol error.
    assign r_code = (m_axi.rlast != last_beat && m_axi.rresp < SLVERR)
                  ? SLVERR : m_axi.rresp;

    assign err_cmd = err_q;
    assign resp    = resp_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        cmd_ready       = 1'b0;
        busy            = state != IDLE;
        done            = 1'b0;
        wd_ready        = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
        rd_last         = 1'b0;
        m_axi.araddr    = '0;
        m_axi.arlen     = '0;
        m_axi.arsize    = '0;
        m_axi.arburst   = '0;
        m_axi.arvalid   = 1'b0;
        m_axi.rready    = 1'b0;
        m_axi.awaddr    = '0;
        m_axi.awlen     = '0;
        m_axi.awsize    = '0;
        m_axi.awburst   = '0;
        m_axi.awvalid   = 1'b0;
        m_axi.wdata     = '0;
        m_axi.wstrb     = '0;
        m_axi.wlast     = 1'b0;
        m_axi.wvalid    = 1'b0;
        m_axi.bready    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !reject)
                    state_nx = cmd_write ? WADDR : RADDR;
            end
            RADDR: begin
                m_axi.araddr  = addr_q;
                m_axi.arlen   = len_q;
                m_axi.arsize  = SIZE;
                m_axi.arburst = burst_q;
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) state_nx = RDATA;
            end
            RDATA: begin
                m_axi.rready = rd_ready;
                rd_valid     = m_axi.rvalid;
                rd_data      = m_axi.rdata;
                rd_last      = m_axi.rlast;
                if (m_axi.rvalid && rd_ready && last_beat)
                    state_nx = DONE;
            end
            WADDR: begin
                m_axi.awaddr  = addr_q;
                m_axi.awlen   = len_q;
                m_axi.awsize  = SIZE;
                m_axi.awburst = burst_q;
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) state_nx = WDATA;
            end
            WDATA: begin
                m_axi.wvalid = wd_valid;
                m_axi.wdata  = wd_data;
                m_axi.wstrb  = '1;
                m_axi.wlast  = last_beat;
                wd_ready     = m_axi.wready;
                if (wd_valid && m_axi.wready && last_beat)
                    state_nx = WRESP;
            end
            WRESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= FIXED;
            beat_cnt <= '0;
            resp_q   <= OKAY;
            err_q    <= 1'b0;
        end else begin
            err_q <= cmd_hs && reject;
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                burst_q <= cmd_burst;
                resp_q  <= OKAY;
            end
            if (a_hs)
                beat_cnt <= '0;
            else if (r_hs || w_hs)
                beat_cnt <= beat_cnt + 8'd1;
            if (r_hs && r_code > resp_q)
                resp_q <= r_code;
            if (b_hs && m_axi.bresp > resp_q)
                resp_q <= m_axi.bresp;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: reactive AXI slave, directed vector table,
// randomized commands against a transaction-level model, and a reset case.
module tb_axi_burst_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 16;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, err_cmd, busy;
    logic [1:0]  resp;

    axi_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_burst_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN(ML)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .resp(resp), .err_cmd(err_cmd), .busy(busy),
        .m_axi(bus.master)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          bad_beat;
        logic [1:0]  bad_code;
        int          last_beat;
        logic [1:0]  bresp;
        int          rd_mode;
        bit          exp_rej;
        logic [1:0]  exp_resp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // slave configuration and live state
    logic [1:0]  cfg_rresp [256];
    int          cfg_last;
    logic [1:0]  cfg_bresp;
    int          rd_mode;
    bit          rnd_rdy;
    int          r_left, r_idx, w_need, w_cnt;
    logic [31:0] r_base;
    bit          b_pend, tog, cmd_pend;
    logic [31:0] wd_q [$];
    logic [31:0] exp_w [$];

    // observations of one transaction
    int          cyc, hs_cyc, first_a;
    int          obs_err, obs_done, obs_ar, obs_aw;
    logic [1:0]  obs_resp;
    logic [31:0] o_addr;
    logic [7:0]  o_len;
    logic [2:0]  o_size;
    logic [1:0]  o_burst;
    bit          o_strb_bad, last_busy, finished;
    logic [31:0] rd_q [$];
    bit          rl_q [$];
    logic [31:0] w_q [$];
    bit          wl_q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_fn(input logic [31:0] b,
                                             input int i);
        return (b ^ 32'h5A5A_0000) + 32'(i) * 32'h0101;
    endfunction

    function automatic bit model_reject(input logic [31:0] a,
                                        input logic [7:0] l,
                                        input logic [1:0] b);
        int beats = int'(l) + 1;
        if (beats > ML) return 1'b1;
        if (b > 2'd1) return 1'b1;
        return b == 2'd1 && int'(a[11:0]) + beats * (DW / 8) > 4096;
    endfunction

    function automatic logic [1:0] model_resp(input bit wr,
                                              input logic [7:0] l);
        logic [1:0] r = 2'b00;
        if (wr) return cfg_bresp;
        for (int i = 0; i <= int'(l); i++) begin
            if (cfg_rresp[i] > r) r = cfg_rresp[i];
            if ((i == cfg_last) != (i == int'(l)) && r < 2'b10) r = 2'b10;
        end
        return r;
    endfunction

    task automatic reset_slave();
        r_left = 0; r_idx = 0; w_need = 0; w_cnt = 0;
        b_pend = 1'b0; tog = 1'b1;
        wd_q.delete();
    endtask

    task automatic clear_obs();
        hs_cyc = -1; first_a = -1;
        obs_err = 0; obs_done = 0; obs_ar = 0; obs_aw = 0;
        obs_resp = 2'b00; o_strb_bad = 1'b0;
        o_addr = '0; o_len = '0; o_size = '0; o_burst = '0;
        rd_q.delete(); rl_q.delete(); w_q.delete(); wl_q.delete();
    endtask

    // drive at negedge, sample settled values 1ns later
    task automatic tick();
        @(negedge aclk);
        bus.arready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rvalid  = r_left > 0 && (!rnd_rdy || $urandom_range(0, 3) != 0);
        bus.rdata   = rdata_fn(r_base, r_idx);
        bus.rresp   = cfg_rresp[r_idx[7:0]];
        bus.rlast   = r_left > 0 && r_idx == cfg_last;
        bus.wready  = !rnd_rdy || $urandom_range(0, 3) != 0;
        bus.bvalid  = b_pend && (!rnd_rdy || $urandom_range(0, 1) != 0);
        bus.bresp   = cfg_bresp;
        wd_valid = wd_q.size() > 0 && (!rnd_rdy || $urandom_range(0, 3) != 0);
        wd_data  = wd_q.size() > 0 ? wd_q[0] : 32'hDEAD_BEEF;
        case (rd_mode)
            0: rd_ready = 1'b1;
            1: begin rd_ready = tog; tog = !tog; end
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        cmd_valid = cmd_pend;
        #1;
        if (cmd_valid && cmd_ready) begin
            cmd_pend = 1'b0;
            hs_cyc = cyc;
        end
        if (err_cmd) obs_err++;
        if (done) begin obs_done++; obs_resp = resp; end
        if ((bus.arvalid || bus.awvalid) && first_a < 0) first_a = cyc;
        if (bus.rvalid && bus.rready) begin r_idx++; r_left--; end
        if (rd_valid && rd_ready) begin
            rd_q.push_back(rd_data);
            rl_q.push_back(rd_last);
        end
        if (bus.arvalid && bus.arready) begin
            obs_ar++;
            o_addr = bus.araddr; o_len = bus.arlen;
            o_size = bus.arsize; o_burst = bus.arburst;
            r_left = int'(bus.arlen) + 1; r_idx = 0; r_base = bus.araddr;
        end
        if (bus.awvalid && bus.awready) begin
            obs_aw++;
            o_addr = bus.awaddr; o_len = bus.awlen;
            o_size = bus.awsize; o_burst = bus.awburst;
            w_need = int'(bus.awlen) + 1; w_cnt = 0;
        end
        if (bus.wvalid && bus.wready) begin
            w_q.push_back(bus.wdata);
            wl_q.push_back(bus.wlast);
            if (bus.wstrb != 4'hF) o_strb_bad = 1'b1;
            w_cnt++;
            if (w_cnt == w_need) b_pend = 1'b1;
        end
        if (wd_valid && wd_ready) void'(wd_q.pop_front());
        if (bus.bvalid && bus.bready) b_pend = 1'b0;
        last_busy = busy;
        cyc++;
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] a,
                           input logic [7:0] l, input logic [1:0] b);
        int post = -1;
        reset_slave();
        clear_obs();
        if (wr)
            for (int i = 0; i <= int'(l); i++) wd_q.push_back($urandom);
        exp_w = wd_q;
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_burst = b;
        cmd_pend = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            tick();
            if (post < 0) begin
                if (obs_done > 0 || obs_err > 0) post = 2;
            end else if (post > 0) begin
                post--;
            end
            if (post == 0) finished = 1'b1;
        end
        cmd_pend = 1'b0;
    endtask

    task automatic check_trans(input string t, input bit wr,
                               input logic [31:0] a, input logic [7:0] l,
                               input logic [1:0] b, input bit rej,
                               input logic [1:0] er);
        int n;
        chk($sformatf("%s.finish", t), finished, 1);
        chk($sformatf("%s.err", t), obs_err, rej);
        if (rej) begin
            chk($sformatf("%s.no_addr", t), obs_ar + obs_aw, 0);
            chk($sformatf("%s.no_done", t), obs_done, 0);
        end else begin
            chk($sformatf("%s.ar", t), obs_ar, !wr);
            chk($sformatf("%s.aw", t), obs_aw, wr);
            chk($sformatf("%s.addr", t), o_addr, a);
            chk($sformatf("%s.len", t), o_len, l);
            chk($sformatf("%s.size", t), o_size, 2);
            chk($sformatf("%s.burst", t), o_burst, b);
            chk($sformatf("%s.lat", t), first_a - hs_cyc, 1);
            n = wr ? w_q.size() : rd_q.size();
            chk($sformatf("%s.beats", t), n, int'(l) + 1);
            for (int i = 0; i < n && i <= int'(l); i++) begin
                if (wr) begin
                    chk($sformatf("%s.wd%0d", t, i), w_q[i], exp_w[i]);
                    chk($sformatf("%s.wl%0d", t, i), wl_q[i], i == int'(l));
                end else begin
                    chk($sformatf("%s.rd%0d", t, i), rd_q[i], rdata_fn(a, i));
                    chk($sformatf("%s.rl%0d", t, i), rl_q[i], i == cfg_last);
                end
            end
            if (wr) chk($sformatf("%s.strb", t), o_strb_bad, 0);
            chk($sformatf("%s.done", t), obs_done, 1);
            chk($sformatf("%s.resp", t), obs_resp, er);
        end
        chk($sformatf("%s.idle", t), last_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec [$];
        bit          wr;
        logic [31:0] a, t;
        logic [7:0]  l;
        logic [1:0]  b;

        cyc = 0; cmd_pend = 1'b0; rnd_rdy = 1'b0; rd_mode = 0;
        cfg_last = 0; cfg_bresp = 2'b00; r_base = '0;
        for (int k = 0; k < 256; k++) cfg_rresp[k] = 2'b00;
        reset_slave();
        clear_obs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_burst = 2'b01;
        wd_valid = 1'b1; wd_data = '0; rd_ready = 1'b1;
        bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = '0; bus.rresp = 2'b00;
        bus.rlast = 1'b0; bus.bvalid = 1'b1; bus.bresp = 2'b00;

        repeat (3) @(negedge aclk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err_cmd, 0);
        chk("rst.avalid", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
        chk("rst.ready", {bus.rready, bus.bready, wd_ready}, 0);
        chk("rst.rd_valid", rd_valid, 0);
        @(negedge aclk);
        areset_n = 1'b1;

        //            wr addr     len    bst  bad cd  last bresp md rej resp
        vec.push_back('{1, 32'h100, 8'd3,  2'd1, -1, 0, 3,  2'd0, 0, 0, 2'd0});
        vec.push_back('{0, 32'h040, 8'd7,  2'd1, -1, 0, 7,  2'd0, 1, 0, 2'd0});
        vec.push_back('{0, 32'h000, 8'd16, 2'd1, -1, 0, 16, 2'd0, 0, 1, 2'd0});
        vec.push_back('{1, 32'h000, 8'd16, 2'd1, -1, 0, 16, 2'd0, 0, 1, 2'd0});
        vec.push_back('{1, 32'hFF8, 8'd3,  2'd1, -1, 0, 3,  2'd0, 0, 1, 2'd0});
        vec.push_back('{0, 32'h080, 8'd3,  2'd1, 1,  2, 3,  2'd0, 0, 0, 2'd2});
        vec.push_back('{0, 32'h0C0, 8'd3,  2'd1, -1, 0, 1,  2'd0, 0, 0, 2'd2});
        vec.push_back('{0, 32'hFF8, 8'd3,  2'd0, -1, 0, 3,  2'd0, 0, 0, 2'd0});
        vec.push_back('{1, 32'h000, 8'd1,  2'd2, -1, 0, 1,  2'd0, 0, 1, 2'd0});
        vec.push_back('{1, 32'h010, 8'd0,  2'd1, -1, 0, 0,  2'd3, 0, 0, 2'd3});
        vec.push_back('{0, 32'hFC0, 8'd15, 2'd1, -1, 0, 15, 2'd0, 0, 0, 2'd0});
        vec.push_back('{0, 32'hFC4, 8'd15, 2'd1, -1, 0, 15, 2'd0, 0, 1, 2'd0});
        vec.push_back('{0, 32'h200, 8'd15, 2'd1, -1, 0, 15, 2'd0, 2, 0, 2'd0});
        vec.push_back('{1, 32'h300, 8'd2,  2'd3, -1, 0, 2,  2'd0, 0, 1, 2'd0});

        foreach (vec[i]) begin
            for (int k = 0; k < 256; k++) cfg_rresp[k] = 2'b00;
            if (vec[i].bad_beat >= 0)
                cfg_rresp[vec[i].bad_beat] = vec[i].bad_code;
            cfg_last = vec[i].last_beat;
            cfg_bresp = vec[i].bresp;
            rd_mode = vec[i].rd_mode;
            rnd_rdy = 1'b0;
            run_cmd(vec[i].wr, vec[i].addr, vec[i].len, vec[i].burst);
            check_trans($sformatf("v%0d", i), vec[i].wr, vec[i].addr,
                        vec[i].len, vec[i].burst, vec[i].exp_rej,
                        vec[i].exp_resp);
        end

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            l  = 8'($urandom_range(0, 17));
            b  = $urandom_range(0, 7) == 0 ? 2'($urandom_range(2, 3))
                                           : 2'($urandom_range(0, 1));
            t  = $urandom;
            if ($urandom_range(0, 1) != 0)
                a = {t[31:12], 12'(4096 - 4 * $urandom_range(1, 20))};
            else
                a = {t[31:2], 2'b00};
            for (int k = 0; k < 256; k++)
                cfg_rresp[k] = $urandom_range(0, 7) == 0
                             ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_last = $urandom_range(0, 4) == 0
                     ? int'($urandom_range(0, int'(l))) : int'(l);
            cfg_bresp = $urandom_range(0, 2) == 0
                      ? 2'($urandom_range(1, 3)) : 2'b00;
            rd_mode = 2;
            rnd_rdy = 1'b1;
            run_cmd(wr, a, l, b);
            check_trans($sformatf("r%0d", n), wr, a, l, b,
                        model_reject(a, l, b), model_resp(wr, l));
        end

        // reset dropped in the middle of a write burst
        rnd_rdy = 1'b0; rd_mode = 0; cfg_bresp = 2'b00;
        reset_slave();
        clear_obs();
        for (int i = 0; i < 8; i++) wd_q.push_back($urandom);
        cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd7;
        cmd_burst = 2'b01; cmd_pend = 1'b1;
        for (int c = 0; c < 50 && w_q.size() < 2; c++) tick();
        chk("mid.beats", w_q.size(), 2);
        @(negedge aclk);
        areset_n = 1'b0;
        #1;
        chk("mid.wvalid", bus.wvalid, 0);
        chk("mid.busy", busy, 0);
        chk("mid.wd_ready", wd_ready, 0);
        obs_done = 0;
        reset_slave();
        repeat (3) tick();
        areset_n = 1'b1;
        repeat (3) tick();
        chk("mid.no_done", obs_done, 0);
        chk("mid.idle", last_busy, 0);
        for (int k = 0; k < 256; k++) cfg_rresp[k] = 2'b00;
        cfg_last = 1;
        run_cmd(1'b0, 32'h300, 8'd1, 2'b01);
        check_trans("post", 1'b0, 32'h300, 8'd1, 2'b01, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
